// File: rtl/byte_serial_add_pkg.sv
// byte_serial_add_pkg: shared types and constants for the byte-serial adder
// controller.
//   state_t    : controller FSM state encoding (IDLE, SETTLE, DONE)
//   BYTE_W     : width of one adder step (8)
//   cnt_width(): width of the settle counter, which counts down from
//                SETTLE_CYCLES-1 to 0. The result is never less than 1 bit.
package byte_serial_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int cnt_width(input int settle_cycles);
    return (settle_cycles > 2) ? $clog2(settle_cycles) : 1;
  endfunction

endpackage

// File: rtl/dut.sv
// dut: gate-level 8-bit ripple-carry adder built from full-adder cells.
// Ports:
//   ain, bin [7:0] : addends
//   cin            : carry-in to bit 0
//   sum     [7:0]  : sum
//   cout           : carry-out of bit 7
// It is purely combinational. Its outputs are valid only after the carry
// has rippled through all eight stages.
module dut (
  input  logic [7:0] ain,
  input  logic [7:0] bin,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    logic p;
    assign p        = ain[i] ^ bin[i];
    assign sum[i]   = p ^ c[i];
    assign c[i + 1] = (ain[i] & bin[i]) | (p & c[i]);
  end

  assign cout = c[8];

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl: performs an (8*NBYTES)-bit add by stepping one
// shared 8-bit ripple adder across the operands, least-significant byte
// first. Each byte is held on the adder for SETTLE_CYCLES clocks before
// the sum byte and carry are captured.
//
// Parameters:
//   NBYTES        : operand width in bytes (>= 1)
//   SETTLE_CYCLES : clocks each byte is held on the adder (>= 1)
// Ports:
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : operand handshake (a, b, cin[, sub])
//   out_valid/out_ready : result handshake (sum, cout)
//   busy              : high whenever the FSM is not in IDLE
//   state_dbg         : current FSM state, for observation only
// Build option:
//   BSA_SUB_EN : adds the 'sub' input. When sub=1, B is inverted into the
//                adder and the initial carry is forced to 1, giving a-b.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on state, never on in_valid. out_valid stays high
// and sum/cout hold until out_ready is seen. A new operand is never
// accepted on the edge that completes the output handshake.
module byte_serial_add_ctrl
  import byte_serial_add_pkg::*;
#(
  parameter int NBYTES        = 4,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*NBYTES-1:0]      a,
  input  logic [8*NBYTES-1:0]      b,
  input  logic                     cin,
`ifdef BSA_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*NBYTES-1:0]      sum,
  output logic                     cout,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int CW = cnt_width(SETTLE_CYCLES);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  if (NBYTES < 1) begin : g_bad_nbytes
    $error("byte_serial_add_ctrl: NBYTES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("byte_serial_add_ctrl: SETTLE_CYCLES must be >= 1");
  end

  state_t state, state_next;

  logic [NBYTES-1:0][BYTE_W-1:0] a_r, b_r, sum_r;
  logic [IW-1:0]                 idx;
  logic [CW-1:0]                 cnt;
  logic                          carry;
  logic                          cout_r;
`ifdef BSA_SUB_EN
  logic                          sub_r;
`endif

  logic              accept;
  logic              capture;
  logic [BYTE_W-1:0] add_a, add_b, add_s;
  logic              add_c, add_co;

  dut u_adder (
    .ain  (add_a),
    .bin  (add_b),
    .cin  (add_c),
    .sum  (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The adder only sees registered operand bytes, so nothing from a/b
  // reaches sum combinationally. Outside SETTLE its inputs are held at 0.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_c      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        add_a = a_r[idx];
`ifdef BSA_SUB_EN
        add_b = b_r[idx] ^ {BYTE_W{sub_r}};
`else
        add_b = b_r[idx];
`endif
        add_c = carry;
        if (cnt == '0) begin
          capture = 1'b1;
          if (idx == IDX_LAST) state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      idx    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
`ifdef BSA_SUB_EN
      sub_r  <= 1'b0;
`endif
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      idx   <= '0;
      cnt   <= CNT_INIT;
`ifdef BSA_SUB_EN
      sub_r <= sub;
      carry <= sub ? 1'b1 : cin;
`else
      carry <= cin;
`endif
    end else if (state == SETTLE) begin
      if (capture) begin
        sum_r[idx] <= add_s;
        carry      <= add_co;
        if (idx == IDX_LAST) begin
          cout_r <= add_co;
        end else begin
          idx <= idx + 1'b1;
          cnt <= CNT_INIT;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign sum       = sum_r;
  assign cout      = cout_r;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// tb_byte_serial_add_ctrl: directed bench for byte_serial_add_ctrl at its
// default parameters (NBYTES=4, SETTLE_CYCLES=10). It covers reset, carry
// between bytes, full ripple, output backpressure, abort by reset, and
// subtraction when BSA_SUB_EN is defined.
module tb_byte_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
`ifdef BSA_SUB_EN
  logic        sub_i;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  logic [32:0] exp_q[$];

  byte_serial_add_ctrl #(.NBYTES(4), .SETTLE_CYCLES(10)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef BSA_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_sum"},       64'(sum),       64'd0);
    check({tag, "_cout"},      64'(cout),      64'd0);
    check({tag, "_state"},     64'(state_dbg), 64'd0);
  endtask

  // Offer one operand at a negedge and hold it until it is accepted. Return
  // at the negedge right after the accepting edge.
  task automatic start_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                          input logic cc, input logic ss);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    a        = aa;
    b        = bb;
    cin      = cc;
`ifdef BSA_SUB_EN
    sub_i    = ss;
`else
    if (ss) $display("note: %s requests sub but BSA_SUB_EN is not defined", tag);
`endif
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Change the inputs after acceptance: the result must not follow them.
    a        = $urandom;
    b        = $urandom;
    cin      = 1'(($urandom_range(0, 1)));
    check({tag, "_busy_after_accept"},     64'(busy),      64'd1);
    check({tag, "_in_ready_after_accept"}, 64'(in_ready),  64'd0);
    check({tag, "_state_settle"},          64'(state_dbg), 64'd1);
  endtask

  // Wait for out_valid, counting edges from the accept edge. Called at the
  // negedge right after the accepting edge.
  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"},    64'(lat),       64'd40);
    check({tag, "_state_done"}, 64'(state_dbg), 64'd2);
  endtask

  // Compare against the scoreboard, then complete the output handshake.
  task automatic take_result(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 64'd1, 64'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_sum"},  64'(sum),  64'(e[31:0]));
    check({tag, "_cout"}, 64'(cout), 64'(e[32]));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_after_hs"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_after_hs"},  64'(in_ready),  64'd1);
    check({tag, "_busy_after_hs"},      64'(busy),      64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                        input logic cc, input logic ss,
                        input logic [31:0] exp_sum, input logic exp_cout);
    exp_q.push_back({exp_cout, exp_sum});
    start_op(tag, aa, bb, cc, ss);
    wait_valid(tag);
    take_result(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef BSA_SUB_EN
    sub_i     = 1'b0;
`endif

    // reset
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // carry across bytes and full ripple
    run_op("byte_carry",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
    run_op("full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    run_op("mixed",       32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);
    run_op("top_carry",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    run_op("cin_used",    32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0, 32'hDFAE_BFF1, 1'b0);

    // backpressure: hold out_ready low and offer a second operand
    exp_q.push_back({1'b0, 32'h0000_000F});
    start_op("bp_first", 32'h0000_000A, 32'h0000_0005, 1'b0, 1'b0);
    wait_valid("bp_first");
    for (int i = 0; i < 5; i++) begin
      a        = 32'h0000_0100;
      b        = 32'h0000_0200;
      cin      = 1'b0;
`ifdef BSA_SUB_EN
      sub_i    = 1'b0;
`endif
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_hold_sum",       64'(sum),       64'h0000_000F);
      check("bp_hold_cout",      64'(cout),      64'd0);
      check("bp_hold_in_ready",  64'(in_ready),  64'd0);
      check("bp_hold_out_valid", 64'(out_valid), 64'd1);
    end
    // in_valid stays high through the handshake, and the second operand is
    // accepted one edge later.
    take_result("bp_first");
    exp_q.push_back({1'b0, 32'h0000_0300});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", 64'(busy), 64'd1);
    wait_valid("bp_second");
    take_result("bp_second");

    // abort with reset during byte 1
    start_op("abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("abort_release");
    run_op("after_abort", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0);

`ifdef BSA_SUB_EN
    run_op("sub_borrow",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_no_borrow", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
    run_op("add_after_sub", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_000C, 1'b0);
`endif

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/byte_serial_add_ctrl.md
# byte_serial_add_ctrl

Sequencing controller that performs wide (8×NBYTES-bit) additions by time-multiplexing one instance of the team's gate-level 8-bit ripple adder (`dut`), one byte per step, least-significant byte first. After driving each byte into the adder, it waits a programmable number of settle cycles to cover the adder's gate delays. It then captures the sum byte and carry-out and chains the carry into the next byte. The block sits between a valid/ready operand source and a valid/ready result sink.

## Interface
- `NBYTES`, default 4: operand width in bytes; must be ≥1 (elaboration error otherwise)
- `SETTLE_CYCLES`, default 10: clock cycles each byte is held on the adder before capture; must be ≥1
- `clk` in 1: single clock, rising-edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `in_valid` in 1: operand offer
- `in_ready` out 1: block idle and able to accept
- `a` in 8*NBYTES: operand A
- `b` in 8*NBYTES: operand B
- `cin` in 1: initial carry-in
- `sub` in 1: subtract request; present only with `BSA_SUB_EN`
- `out_valid` out 1: result available
- `out_ready` in 1: sink accepts result
- `sum` out 8*NBYTES: result
- `cout` out 1: carry-out of the most-significant byte
- `busy` out 1: high in any state other than IDLE

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SETTLE: adder inputs driven from the registered byte slice `idx`.
  - DONE: `out_valid`=1.
- IDLE → SETTLE on `in_valid && in_ready`:
  - latch `a`, `b`, and `carry`←`cin`
  - set `idx`←0 and `cnt`←SETTLE_CYCLES-1
- While in SETTLE, the adder sees `ain=a_r[idx]`, `bin=b_r[idx]`, `cin=carry`.
- SETTLE with `cnt`≠0: `cnt` decrements.
- SETTLE with `cnt`==0:
  - `sum_r[idx]`←adder sum and `carry`←adder cout
  - if `idx`==NBYTES-1: go to DONE and `cout`←adder cout
  - otherwise: `idx`++ and `cnt`←SETTLE_CYCLES-1
- DONE → IDLE on `out_ready`. `sum` and `cout` stay stable until the next capture.
- `in_ready` is low in SETTLE and DONE. Input operands are ignored unless accepted.
- No acceptance in the same cycle as the output handshake. The earliest next accept is the cycle after leaving DONE.
- Adder inputs are held at 0 in IDLE and DONE.
- Arithmetic is modulo 2^(8*NBYTES). `cout` is the true carry out of bit 8*NBYTES-1.
- Reset values:
  - state IDLE; `in_ready`=1 (combinational from IDLE)
  - `out_valid`=0, `busy`=0, `sum`=0, `cout`=0
  - `idx`=0, `cnt`=0, `carry`=0
- Reset mid-operation aborts immediately, discards partial results, and returns the block to the reset values above.

## Timing
- The acceptance edge is cycle 0. Each byte occupies exactly SETTLE_CYCLES cycles.
- `out_valid` rises NBYTES×SETTLE_CYCLES cycles after the acceptance edge. Default: 40 cycles.
- Minimum operation period: NBYTES×SETTLE_CYCLES + 2 cycles (accept cycle, compute, DONE with immediate `out_ready`).
- SETTLE_CYCLES × clock period must exceed the adder's worst-case settle path, carry ripple through 8 full-adder stages. Roughly 60 ns with unit gate delays; 100 ns at defaults with a 10 ns clock.
- The captured byte must come from adder outputs settled for the full window. No combinational path exists from `a`/`b` to `sum`.

## Configuration
- `BSA_SUB_EN` defined:
  - adds the `sub` port; `sub` is latched at acceptance.
  - when `sub`=1: B bytes are inverted into the adder and the initial carry is 1 (`cin` ignored), giving `sum`=a-b. `cout`=1 means no borrow.
- `BSA_SUB_EN` undefined: no `sub` port, addition only, `cin` always used.

## Structure
- Package `byte_serial_add_pkg` holds:
  - the state enum (IDLE, SETTLE, DONE)
  - the byte-width constant (8)
  - a function returning the settle-counter width from SETTLE_CYCLES
- One sub-module: the existing 8-bit adder `dut`, instantiated once. The controller contains only registers, counters and the FSM.

## Test plan
- Reset: hold `rst_n`=0 → `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `cout`=0.
- Byte carry: defaults, a=0x000000FF, b=0x00000001, cin=0 → `sum`=0x00000100, `cout`=0. `out_valid` rises exactly 40 cycles after accept.
- Full ripple: a=0xFFFFFFFF, b=0, cin=1 → `sum`=0x00000000, `cout`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` and pulse `in_valid` → `sum`/`cout` stable, `in_ready`=0, second operand not accepted. The next accept occurs the cycle after the handshake.
- Abort: assert `rst_n`=0 during byte 2 of a=0x12345678, b=0x11111111 → all outputs at reset values. A new op with a=1, b=2 → `sum`=3.
- With `BSA_SUB_EN`: `sub`=1, a=5, b=7 → `sum`=0xFFFFFFFE, `cout`=0. With a=7, b=5 → `sum`=2, `cout`=1.
